uart_rx_fetch: RTL and testbench

- Receive-side controller for the board's external UART chip: the reader counterpart to the transmit path that drives wrn and polls tbre/tsre.
- Watches data_ready, performs the rdn read strobe on the shared Ram1Data bus, and captures each byte.
- Buffers captured bytes in a small FIFO and presents them to the CPU/core through a valid/ready stream.
- Holds Ram1 disabled so the SRAM never contends with the UART on the shared bus.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fetch_if.sv | 24 ++
 rtl/byte_fifo.sv | 62 ++++++
 rtl/uart_rx_fetch.sv | 119 +++++++++++
 tb/tb_uart_rx_fetch.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the external UART controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    CAPTURE = 2'd2,
    RECOVER = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fetch_if.sv
// ============================================================================
//  Module      : uart_rx_fetch_if
//  Description : Received-byte stream (valid/ready plus occupancy) to the core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fetch_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) ();

  logic [BYTE_W-1:0]            rx_data;
  logic                         rx_valid;
  logic                         rx_ready;
  logic [$clog2(FIFO_DEPTH):0]  rx_count;

  modport master (output rx_data, output rx_valid, output rx_count, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input rx_count, output rx_ready);

endinterface

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
//  Module      : byte_fifo
//  Description : Power-of-2 circular FIFO with combinational head and count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic                   CLK,
  input  wire logic                   RST,
  input  wire logic                   push,
  input  wire logic [WIDTH-1:0]       push_data,
  input  wire logic                   pop,
  output logic      [WIDTH-1:0]       head,
  output logic      [$clog2(DEPTH):0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rptr];
  assign count  = r_count;

  // Pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fetch.sv
// ============================================================================
//  Module      : uart_rx_fetch
//  Description : Strobes rdn on data_ready, captures Ram1Data bytes into a FIFO.
//                Build option RX_STATUS_LED_EN drives L with the last byte.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fetch
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int RD_LOW_CYCLES = 2
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  input  wire logic              enable,
  input  wire logic              data_ready,
  input  wire logic [BYTE_W-1:0] ram1_data,
  output logic                   rdn,
  output logic                   ram1_en,
  output logic                   ram1_oe,
  output logic                   ram1_we,
  output logic      [BYTE_W-1:0] L,
  uart_rx_fetch_if.master        rx
);

  localparam int CNT_W = (RD_LOW_CYCLES > 1) ? $clog2(RD_LOW_CYCLES) : 1;

  rx_state_t               r_state;
  rx_state_t               w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_dr_sync;
  logic                    w_dr_s;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_rdn;
  logic                    w_rdn_nxt;
  logic                    w_push;
  logic                    w_full;
  logic                    w_empty;

  assign ram1_en = 1'b1;
  assign ram1_oe = 1'b1;
  assign ram1_we = 1'b1;
  assign rdn     = r_rdn;
  assign w_dr_s  = r_dr_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_dr_sync <= '0;
    else      r_dr_sync <= {r_dr_sync[SYNC_STAGES-2:0], data_ready};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdn   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rdn   <= w_rdn_nxt;
      if (r_state != STROBE && w_state_nxt == STROBE)
        r_cnt <= CNT_W'(RD_LOW_CYCLES - 1);
      else if (r_state == STROBE && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Free space is only checked here; one read in flight always fits
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = (w_dr_s && enable && !w_full) ? STROBE : IDLE;
      STROBE:  w_state_nxt = (r_cnt == '0) ? CAPTURE : STROBE;
      CAPTURE: w_state_nxt = RECOVER;
      RECOVER: w_state_nxt = w_dr_s ? RECOVER : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // rdn is registered from the next state so it changes cleanly on the edge
  always_comb begin
    w_rdn_nxt = 1'b1;
    w_push    = 1'b0;
    if (w_state_nxt == STROBE || w_state_nxt == CAPTURE) w_rdn_nxt = 1'b0;
    if (r_state == CAPTURE) w_push = 1'b1;
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (w_push),
    .push_data (ram1_data),
    .pop       (rx.rx_ready),
    .head      (rx.rx_data),
    .count     (rx.rx_count),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign rx.rx_valid = !w_empty;

`ifdef RX_STATUS_LED_EN
  logic [BYTE_W-1:0] r_led;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         r_led <= '0;
    else if (w_push)  r_led <= ram1_data;
  end

  assign L = r_led;
`else
  assign L = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fetch.sv
// ============================================================================
//  Module      : tb_uart_rx_fetch
//  Description : Directed self-checking bench for uart_rx_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fetch;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       enable = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] ram1_data = 8'h00;
  logic       rdn, ram1_en, ram1_oe, ram1_we;
  logic [7:0] L;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int max_cnt  = 0;
  logic [7:0] exp_q [$];

  uart_rx_fetch_if #(.FIFO_DEPTH(8)) rx_if ();

  uart_rx_fetch #(.FIFO_DEPTH(8), .RD_LOW_CYCLES(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .data_ready (data_ready),
    .ram1_data  (ram1_data),
    .rdn        (rdn),
    .ram1_en    (ram1_en),
    .ram1_oe    (ram1_oe),
    .ram1_we    (ram1_we),
    .L          (L),
    .rx         (rx_if)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge rdn) pulses++;

  // Consumer: every accepted byte must match the next expected byte
  always @(negedge CLK) begin
    if (RST) begin
      if (32'(rx_if.rx_count) > max_cnt) max_cnt = 32'(rx_if.rx_count);
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        if (exp_q.size() == 0) chk("rx_unexpected", 32'(exp_q.size()), 32'd1);
        else                   chk("rx_data", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_rdn(input logic v, input string tag);
    int k = 0;
    while (rdn !== v && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, 32'(rdn), 32'(v));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    ram1_data  = b;
    data_ready = 1'b1;
    wait_rdn(1'b0, "rdn_fall");
    wait_rdn(1'b1, "rdn_rise");
    @(posedge CLK); #1;
    data_ready = 1'b0;
    repeat (3) @(posedge CLK);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((rx_if.rx_valid || exp_q.size() != 0) && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic v6;
    int   lowcnt;
    int   p;
    logic [7:0] exp_led;

    rx_if.rx_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("rst_rdn",   32'(rdn), 32'd1);
    chk("rst_ram1",  32'({ram1_en, ram1_oe, ram1_we}), 32'h7);
    chk("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("rst_count", 32'(rx_if.rx_count), 32'd0);
    chk("rst_data",  32'(rx_if.rx_data), 32'h00);
    chk("rst_led",   32'(L), 32'h00);

    // rx_ready on an empty FIFO must not move anything
    @(posedge CLK); #1 rx_if.rx_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 rx_if.rx_ready = 1'b0;
    @(negedge CLK);
    chk("empty_pop_count", 32'(rx_if.rx_count), 32'd0);

    // Single byte: cycle 1 is the one in which data_ready rises
    @(posedge CLK); #1;
    ram1_data  = 8'hA5;
    data_ready = 1'b1;
    lowcnt = 0;
    v6 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      if (rdn == 1'b0) lowcnt++;
      if (c == 3) chk("rdn_c3_high", 32'(rdn), 32'd1);
      if (c == 4) chk("rdn_c4_low", 32'(rdn), 32'd0);
      if (c == 6) v6 = rx_if.rx_valid;
    end
    chk("valid_c6", 32'(v6), 32'd0);
    chk("valid_c7", 32'(rx_if.rx_valid), 32'd1);
    chk("data_c7",  32'(rx_if.rx_data), 32'hA5);
    chk("count_c7", 32'(rx_if.rx_count), 32'd1);
    chk("rdn_width", 32'(lowcnt), 32'd3);
    @(posedge CLK); #1 data_ready = 1'b0;
`ifdef RX_STATUS_LED_EN
    exp_led = 8'hA5;
`else
    exp_led = 8'h00;
`endif
    @(negedge CLK);
    chk("led_a5", 32'(L), 32'(exp_led));
    exp_q.push_back(8'hA5);
    @(posedge CLK); #1 rx_if.rx_ready = 1'b1;
    drain("drain_single");
    @(posedge CLK); #1 rx_if.rx_ready = 1'b0;
    repeat (3) @(posedge CLK);

    // Burst to full, then a blocked ninth byte
    for (int b = 1; b <= 8; b++) begin
      send_byte(8'(b));
      exp_q.push_back(8'(b));
    end
    @(negedge CLK);
    chk("full_count", 32'(rx_if.rx_count), 32'd8);
    @(posedge CLK); #1;
    ram1_data  = 8'h09;
    data_ready = 1'b1;
    p = pulses;
    repeat (20) @(negedge CLK);
    chk("full_no_pulse", 32'(pulses), 32'(p));
    chk("full_rdn_high", 32'(rdn), 32'd1);
    exp_q.push_back(8'h09);
    @(posedge CLK); #1 rx_if.rx_ready = 1'b1;
    wait_rdn(1'b0, "ninth_fall");
    wait_rdn(1'b1, "ninth_rise");
    @(posedge CLK); #1 data_ready = 1'b0;
    drain("drain_burst");

    // Wrap-around with a consumer that is always ready
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'h40 + 8'(i));
      send_byte(8'h40 + 8'(i));
    end
    drain("drain_wrap");
    chk("wrap_max_le2", 32'(max_cnt <= 2), 32'd1);

    // Stuck data_ready yields exactly one read
    p = pulses;
    exp_q.push_back(8'h5A);
    @(posedge CLK); #1;
    ram1_data  = 8'h5A;
    data_ready = 1'b1;
    wait_rdn(1'b0, "stuck_fall");
    wait_rdn(1'b1, "stuck_rise");
    repeat (20) @(negedge CLK);
    chk("stuck_one_pulse", 32'(pulses), 32'(p + 1));
    @(posedge CLK); #1 data_ready = 1'b0;
    repeat (4) @(posedge CLK);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    drain("drain_stuck");
    chk("stuck_then_next", 32'(pulses), 32'(p + 2));

    // enable low blocks new reads until raised
    p = pulses;
    @(posedge CLK); #1;
    enable     = 1'b0;
    ram1_data  = 8'h77;
    data_ready = 1'b1;
    repeat (10) @(negedge CLK);
    chk("disabled_no_pulse", 32'(pulses), 32'(p));
    exp_q.push_back(8'h77);
    @(posedge CLK); #1 enable = 1'b1;
    wait_rdn(1'b0, "enable_fall");
    wait_rdn(1'b1, "enable_rise");
    @(posedge CLK); #1 data_ready = 1'b0;
    drain("drain_enable");

    // Reset in the middle of a strobe discards everything
    @(posedge CLK); #1 rx_if.rx_ready = 1'b0;
    send_byte(8'h11);
    @(posedge CLK); #1;
    ram1_data  = 8'h22;
    data_ready = 1'b1;
    wait_rdn(1'b0, "mid_fall");
    #2 RST = 1'b0;
    #1 chk("rst_mid_rdn", 32'(rdn), 32'd1);
    data_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("rst_mid_count", 32'(rx_if.rx_count), 32'd0);
    chk("rst_mid_led",   32'(L), 32'h00);

    // Status LED after a fresh capture
    send_byte(8'h3C);
`ifdef RX_STATUS_LED_EN
    exp_led = 8'h3C;
`else
    exp_led = 8'h00;
`endif
    @(negedge CLK);
    chk("led_3c",  32'(L), 32'(exp_led));
    chk("data_3c", 32'(rx_if.rx_data), 32'h3C);
    exp_q.push_back(8'h3C);
    @(posedge CLK); #1 rx_if.rx_ready = 1'b1;
    drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
